wishbone_uart_rx: RTL and testbench
===================================

Name: wishbone_uart_rx

Overview:
- Wishbone slave UART receiver; the receive-side counterpart of the UART transmitter on the same bus.
- Samples `ser_rx` at 8N1 and buffers received bytes in a small FIFO.
- The CPU reads data and status registers over Wishbone.
- Raises a level interrupt while data is pending.

Parameters:
- ClkFreq, 20000000, system clock frequency in Hz.
- BoundRate, 115200, serial bit rate.
- FifoDepth, 8, receive FIFO entries; power of two, from 2 to 16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ser_rx  in  1  serial input, idle high.
- wishbone_addr_i  in  32  byte address; only bits [3:2] decoded.
- wishbone_data_i  in  32  write data.
- wishbone_we_i  in  1  write enable.
- wishbone_sel_i  in  4  byte select; ignored.
- wishbone_stb_i  in  1  strobe.
- wishbone_cyc_i  in  1  cycle.
- wishbone_data_o  out  32  read data, registered.
- wishbone_ack_o  out  1  single-cycle acknowledge.
- rx_irq_o  out  1  high while the FIFO is not empty.

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE; 2-flop `ser_rx` synchronizer preset to 1.
  - FIFO empty; all flags 0.
  - wishbone_ack_o=0, wishbone_data_o=0, rx_irq_o=0.
  - A frame in progress is discarded. Reception resumes on the first falling edge after rst deasserts.
- Timing constants: Div = ClkFreq/BoundRate (integer; 173 at defaults); Half = Div/2 (86).
- RX FSM, driven by the synchronized rx, 10-bit divcnt, 3-bit bitcnt:
  - IDLE: rx==0 -> START, divcnt=0.
  - START: at divcnt==Half-1, sample rx. If 0 -> DATA, divcnt=0, bitcnt=0. If 1 -> IDLE (glitch, no flag).
  - DATA: at divcnt==Div-1, shift the sample in LSB-first, divcnt=0. After bitcnt==7 -> STOP (PARITY when enabled).
  - STOP: at divcnt==Div-1, sample rx.
    - 1: push the byte into the FIFO. If the FIFO is full and no pop occurs this cycle, drop the byte and set `overrun`.
    - 0: set `frame_err` and discard the byte.
    - Either way -> IDLE at mid-stop-bit, so back-to-back frames are accepted.
- FIFO:
  - First-word-fall-through.
  - Pointers are log2(FifoDepth)+1 bits and wrap naturally.
  - Push and pop in the same cycle: both take effect, including when full or empty-with-push; no overrun in that case.
- Wishbone:
  - req = cyc & stb.
  - ack registered: ack <= req & ~ack. This gives 1-cycle latency; ack is high for exactly one cycle per req, and the master must drop stb after ack.
  - data_o is loaded in the same cycle ack rises and is 0 whenever ack is 0.
- Registers, selected by addr[3:2]:
  - 0 DATA (read): {24'b0, head byte}; pops on the acked cycle. FIFO empty: returns 0, no pop.
  - 0 DATA (write): ignored, still acked.
  - 1 STATUS (read):
    - bit0 not empty; bit1 full; bit2 overrun; bit3 frame_err; bit4 parity_err (0 when feature absent).
    - [12:8] FIFO count.
    - All other bits 0.
  - 1 STATUS (write): write-1-to-clear bits 2-4. If a set and a clear hit the same cycle, the set wins.
  - 2, 3: read 0, writes ignored, acked.
- rx_irq_o: combinational from the registered FIFO state (not empty).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP; parity bit sampled at divcnt==Div-1.
  - Even parity expected. On mismatch, set `parity_err` and discard the byte; the stop bit is still checked.
- Undefined: no PARITY state, plain 8N1, STATUS bit4 tied 0.

Decomposition:
- Shared defines include `uart_defines.v` holds:
  - RX FSM state encodings (IDLE, START, DATA, PARITY, STOP).
  - Register offsets: DATA=2'd0, STATUS=2'd1.
  - STATUS bit indices.
  - The shared Div computation, so TX and RX use the same value.
- One sub-module: `uart_rx_fifo`.
  - Parameters: width 8, FifoDepth.
  - Ports: clk, rst, push, din, pop, dout, empty, full, count.

Test Plan:
- Byte receive: drive 0x55 8N1 at 173 clk/bit -> STATUS reads 0x101 (count 1, not empty), rx_irq_o=1 -> DATA read returns 0x55 -> STATUS returns 0x000, rx_irq_o=0.
- Glitch rejection: rx low for 40 clk, then high -> no push, STATUS=0, FSM back in IDLE.
- Framing error: 0xA3 with stop bit 0 -> STATUS bit3=1, FIFO empty -> write 0x08 to STATUS -> bit3 clears.
- Overrun: 9 back-to-back bytes 0x00..0x08, no reads -> STATUS full=1, overrun=1, count 8 -> 8 DATA reads return 0x00..0x07 in order; a 9th read returns 0.
- Bus timing: stb+cyc held 1 cycle on an empty FIFO -> ack exactly 1 cycle later for 1 cycle, data_o=0; simultaneous push and pop on a full FIFO -> count stays 8, no overrun.
- Reset mid-frame: assert rst during bit 4 of 0x5A -> outputs 0 immediately, FIFO empty; next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/wishbone_uart_rx_pkg.sv
// wishbone_uart_rx_pkg: receiver state encodings, register map, STATUS bit indices and shared bit-period helper
package wishbone_uart_rx_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int ST_NOT_EMPTY  = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_OVERRUN    = 2;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_PARITY_ERR = 4;
    localparam int ST_COUNT_LSB  = 8;

    function automatic int bit_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO; pointers carry an extra wrap bit
module uart_rx_fifo #(
    parameter int Width     = 8,
    parameter int FifoDepth = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [Width-1:0]           din,
    input  logic                       pop,
    output logic [Width-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(FifoDepth):0] count
);
    localparam int AW = $clog2(FifoDepth);
    localparam logic [AW:0] FULL_CNT = FifoDepth[AW:0];

    logic [Width-1:0] mem [FifoDepth];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = count == FULL_CNT;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, do_push};
            rd_ptr <= rd_ptr + {{AW{1'b0}}, do_pop};
        end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;

endmodule

// File: rtl/wishbone_uart_rx.sv
// wishbone_uart_rx: Wishbone slave 8N1 UART receiver with FWFT FIFO and level IRQ while data is pending.
// Define UART_RX_PARITY_EN to expect an even parity bit between the data bits and the stop bit.
module wishbone_uart_rx
    import wishbone_uart_rx_pkg::*;
#(
    parameter int ClkFreq   = 20000000,
    parameter int BoundRate = 115200,
    parameter int FifoDepth = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ser_rx,
    input  logic [31:0] wishbone_addr_i,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_we_i,
    input  logic [3:0]  wishbone_sel_i,
    input  logic        wishbone_stb_i,
    input  logic        wishbone_cyc_i,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_ack_o,
    output logic        rx_irq_o
);
    localparam int Div = bit_div(ClkFreq, BoundRate);
    localparam int CW  = $clog2(FifoDepth) + 1;
    localparam logic [9:0] DIV_LAST  = 10'(Div - 1);
    localparam logic [9:0] HALF_LAST = 10'(Div / 2 - 1);

    rx_state_t state, state_n;
    logic rx_meta, rx_s;
    logic [9:0] divcnt, divcnt_n;
    logic [2:0] bitcnt, bitcnt_n;
    logic [7:0] shreg, shreg_n;
    logic par_bad, par_bad_n;
    logic rx_push, frame_set, par_set, ovr_set;
    logic [7:0] fifo_dout;
    logic fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic overrun, frame_err, parity_err;
    logic req, ack_set, pop, st_wr;
    logic [1:0] reg_sel;
    logic [31:0] status, rdata;
    logic unused_bits;

    assign unused_bits = ^{wishbone_sel_i, wishbone_addr_i[31:4], wishbone_addr_i[1:0],
                           wishbone_data_i[31:5], wishbone_data_i[1:0]};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= RX_IDLE;
            divcnt  <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else begin
            rx_meta <= ser_rx;
            rx_s    <= rx_meta;
            state   <= state_n;
            divcnt  <= divcnt_n;
            bitcnt  <= bitcnt_n;
            shreg   <= shreg_n;
            par_bad <= par_bad_n;
        end

    always_comb begin
        state_n   = state;
        divcnt_n  = divcnt + 10'd1;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        par_bad_n = par_bad;
        rx_push   = 1'b0;
        frame_set = 1'b0;
        par_set   = 1'b0;
        case (state)
            RX_IDLE: begin
                divcnt_n = '0;
                if (!rx_s) state_n = RX_START;
            end
            RX_START:
                if (divcnt == HALF_LAST) begin
                    divcnt_n  = '0;
                    bitcnt_n  = '0;
                    par_bad_n = 1'b0;
                    state_n   = rx_s ? RX_IDLE : RX_DATA;
                end
            RX_DATA:
                if (divcnt == DIV_LAST) begin
                    divcnt_n = '0;
                    shreg_n  = {rx_s, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bitcnt == 3'd7) state_n = RX_PARITY;
`else
                    if (bitcnt == 3'd7) state_n = RX_STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
            RX_PARITY:
                if (divcnt == DIV_LAST) begin
                    divcnt_n  = '0;
                    par_bad_n = ^{shreg, rx_s};
                    par_set   = ^{shreg, rx_s};
                    state_n   = RX_STOP;
                end
`endif
            // leave at mid-stop-bit so a start bit right behind it is not missed
            RX_STOP:
                if (divcnt == DIV_LAST) begin
                    divcnt_n  = '0;
                    rx_push   = rx_s & ~par_bad;
                    frame_set = ~rx_s;
                    state_n   = RX_IDLE;
                end
            default: state_n = RX_IDLE;
        endcase
    end

    uart_rx_fifo #(.Width(8), .FifoDepth(FifoDepth)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (shreg),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign req     = wishbone_cyc_i & wishbone_stb_i;
    assign ack_set = req & ~wishbone_ack_o;
    assign reg_sel = wishbone_addr_i[3:2];
    assign pop     = ack_set & ~wishbone_we_i & (reg_sel == REG_DATA) & ~fifo_empty;
    assign st_wr   = ack_set & wishbone_we_i & (reg_sel == REG_STATUS);
    assign ovr_set = rx_push & fifo_full & ~pop;
    assign rx_irq_o = ~fifo_empty;

    always_comb begin
        status = '0;
        status[ST_NOT_EMPTY]  = ~fifo_empty;
        status[ST_FULL]       = fifo_full;
        status[ST_OVERRUN]    = overrun;
        status[ST_FRAME_ERR]  = frame_err;
        status[ST_PARITY_ERR] = parity_err;
        status[ST_COUNT_LSB +: CW] = fifo_count;
    end

    assign rdata = wishbone_we_i ? '0 :
                   reg_sel == REG_DATA   ? {24'b0, fifo_empty ? 8'h00 : fifo_dout} :
                   reg_sel == REG_STATUS ? status : '0;

    // sticky error flags: write-1-to-clear, a new event in the same cycle wins
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            overrun         <= 1'b0;
            frame_err       <= 1'b0;
            parity_err      <= 1'b0;
            wishbone_ack_o  <= 1'b0;
            wishbone_data_o <= '0;
        end else begin
            overrun         <= ovr_set | (overrun & ~(st_wr & wishbone_data_i[ST_OVERRUN]));
            frame_err       <= frame_set | (frame_err & ~(st_wr & wishbone_data_i[ST_FRAME_ERR]));
            parity_err      <= par_set | (parity_err & ~(st_wr & wishbone_data_i[ST_PARITY_ERR]));
            wishbone_ack_o  <= ack_set;
            wishbone_data_o <= ack_set ? rdata : '0;
        end

endmodule

// File: tb/tb_wishbone_uart_rx.sv
// tb_wishbone_uart_rx: randomized self-checking bench against a queue-based receiver model
module tb_wishbone_uart_rx;
    localparam int DIV   = 20000000 / 115200;
    localparam int HALF  = DIV / 2;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ser_rx = 1'b1;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_sel = '0;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic [31:0] wb_dout;
    logic        wb_ack;
    logic        rx_irq;

    wishbone_uart_rx #(.ClkFreq(20000000), .BoundRate(115200), .FifoDepth(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .ser_rx          (ser_rx),
        .wishbone_addr_i (wb_addr),
        .wishbone_data_i (wb_wdata),
        .wishbone_we_i   (wb_we),
        .wishbone_sel_i  (wb_sel),
        .wishbone_stb_i  (wb_stb),
        .wishbone_cyc_i  (wb_cyc),
        .wishbone_data_o (wb_dout),
        .wishbone_ack_o  (wb_ack),
        .rx_irq_o        (rx_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];
    bit m_ovr = 0;
    bit m_ferr = 0;
    int ack_lat;
    logic ack_after;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {19'b0, 5'(q.size()), 3'b0, 1'b0, m_ferr, m_ovr, q.size() == DEPTH, q.size() != 0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit good_stop);
        ser_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        if (good_stop) begin
            ser_rx = 1'b1;
            repeat (DIV) @(negedge clk);
        end else begin
            ser_rx = 1'b0;
            repeat (HALF + 14) @(negedge clk);
            ser_rx = 1'b1;
            repeat (DIV - HALF - 14) @(negedge clk);
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit good);
        send_frame(b, good);
        if (!good) m_ferr = 1;
        else if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1;
    endtask

    task automatic wb_xfer(input logic [1:0] reg_i, input bit we, input logic [31:0] wdata,
                           output logic [31:0] rdata);
        wb_addr  = ($urandom() & 32'hFFFF_FFF3) | {28'b0, reg_i, 2'b00};
        wb_we    = we;
        wb_wdata = wdata;
        wb_sel   = 4'($urandom());
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        ack_lat  = 0;
        do begin
            @(posedge clk);
            #1;
            ack_lat++;
        end while (!wb_ack && ack_lat < 8);
        if (!wb_ack) chk("ack_timeout", {31'b0, wb_ack}, 32'd1);
        rdata  = wb_dout;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        @(posedge clk);
        #1;
        ack_after = wb_ack;
        @(negedge clk);
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] d;
        logic [7:0] e;
        e = q.size() != 0 ? q.pop_front() : 8'h00;
        wb_xfer(2'd0, 1'b0, '0, d);
        chk(tag, d, {24'b0, e});
    endtask

    task automatic rd_status(input string tag);
        logic [31:0] d;
        wb_xfer(2'd1, 1'b0, '0, d);
        chk(tag, d, exp_status());
    endtask

    task automatic clr_status(input logic [31:0] mask);
        logic [31:0] d;
        wb_xfer(2'd1, 1'b1, mask, d);
        if (mask[2]) m_ovr = 0;
        if (mask[3]) m_ferr = 0;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0] nb, e;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, wb_ack}, 32'd0);
        chk("rst_dout", wb_dout, 32'd0);
        chk("rst_irq", {31'b0, rx_irq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rd_status("rst_status");

        rx_byte(8'h55, 1);
        rd_status("st_55");
        chk("irq_55", {31'b0, rx_irq}, 32'd1);
        rd_data("data_55");
        rd_status("st_55_empty");
        chk("irq_55_clr", {31'b0, rx_irq}, 32'd0);

        ser_rx = 1'b0;
        repeat (40) @(negedge clk);
        ser_rx = 1'b1;
        repeat (300) @(negedge clk);
        rd_status("glitch");

        rx_byte(8'hA3, 0);
        rd_status("frame_err");
        clr_status(32'h08);
        rd_status("frame_err_clr");

        for (int i = 0; i < 9; i++) rx_byte(8'(i), 1);
        rd_status("overrun");
        for (int i = 0; i < 9; i++) rd_data($sformatf("ovr_data%0d", i));
        rd_status("ovr_drained");
        clr_status(32'h04);
        rd_status("ovr_clr");

        wb_xfer(2'd0, 1'b0, '0, d);
        chk("t_empty_data", d, 32'd0);
        chk("t_latency", ack_lat, 32'd1);
        chk("t_ack_once", {31'b0, ack_after}, 32'd0);
        chk("t_dout_idle", wb_dout, 32'd0);
        wb_xfer(2'd0, 1'b1, 32'hFFFF_FFFF, d);
        chk("t_wr_data_ack", ack_lat, 32'd1);
        wb_xfer(2'd2, 1'b1, 32'hFFFF_FFFF, d);
        wb_xfer(2'd3, 1'b0, '0, d);
        chk("t_reg3", d, 32'd0);
        rd_status("t_status_after_wr");

        for (int i = 0; i < DEPTH; i++) rx_byte(8'($urandom()), 1);
        rd_status("full_again");
        nb = 8'($urandom());
        e = q[0];
        fork
            send_frame(nb, 1);
            begin
                repeat (HALF + 9 * DIV + 2) @(negedge clk);
                wb_xfer(2'd0, 1'b0, '0, d);
            end
        join
        chk("simul_data", d, {24'b0, e});
        void'(q.pop_front());
        q.push_back(nb);
        rd_status("simul_status");
        for (int i = 0; i < DEPTH; i++) rd_data($sformatf("simul_drain%0d", i));

        rx_byte(8'($urandom()), 1);
        chk("pre_rst_irq", {31'b0, rx_irq}, 32'd1);
        fork
            send_frame(8'h5A, 1);
            begin
                repeat (5 * DIV + 60) @(negedge clk);
                rst = 1'b1;
                #1;
                chk("mid_rst_ack", {31'b0, wb_ack}, 32'd0);
                chk("mid_rst_dout", wb_dout, 32'd0);
                chk("mid_rst_irq", {31'b0, rx_irq}, 32'd0);
            end
        join
        rst = 1'b0;
        q.delete();
        m_ovr = 0;
        m_ferr = 0;
        @(negedge clk);
        rd_status("post_rst");
        rx_byte(8'h3C, 1);
        rd_data("data_3c");

        for (int it = 0; it < 10; it++) begin
            rx_byte(8'($urandom()), $urandom_range(0, 4) != 0);
            for (int r = $urandom_range(0, 2); r > 0; r--) rd_data($sformatf("rnd_data%0d", it));
            rd_status($sformatf("rnd_status%0d", it));
            chk($sformatf("rnd_irq%0d", it), {31'b0, rx_irq}, {31'b0, q.size() != 0});
            if ($urandom_range(0, 2) == 0) clr_status($urandom() & 32'h0C);
        end
        rd_status("final_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
